// File: rtl/prbs_pkg.sv
// Shared definitions for the 14-bit PRBS (x^14+x^5+x^3+x^1+1) generator and checker.
// The polynomial lives only here, so both ends of the link step the same way.
package prbs_pkg;

    localparam int PRBS_W = 14;
    localparam int POP_W  = 4;

    // Feedback taps on state bits 13, 4, 2 and 0.
    localparam logic [PRBS_W-1:0] PRBS_TAPS = 14'h2015;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    function automatic logic [PRBS_W-1:0] prbs_next(input logic [PRBS_W-1:0] s);
        return {^(s & PRBS_TAPS), s[PRBS_W-1:1]};
    endfunction

endpackage

// File: rtl/prbs_popcount.sv
// Combinational population count of a PRBS-width vector.
module prbs_popcount
    import prbs_pkg::*;
(
    input  logic [PRBS_W-1:0] vec,
    output logic [POP_W-1:0]  cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < PRBS_W; i++) begin
            cnt = cnt + POP_W'(vec[i]);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: locks onto the incoming state words, then flywheels its
// own expected sequence and reports per-word errors plus saturating error counters.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_THR = 8,
    parameter int LOSS_THR = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // rx_valid qualifies rx_bus for exactly one cycle; there is no back-pressure,
    // so every cycle with rx_valid=1 is consumed as one PRBS word.
    input  logic              rx_valid,
    input  logic [PRBS_W-1:0] rx_bus,
    input  logic              err_clr,
    output logic              locked,
    output logic              err_word,
    output logic [POP_W-1:0]  err_bits,
    output logic [CNT_W-1:0]  word_err_cnt,
    output logic [CNT_W-1:0]  bit_err_cnt
);

    localparam int GOOD_W = $clog2(LOCK_THR + 1);
    localparam int BAD_W  = $clog2(LOSS_THR + 1);

    chk_state_e        state_q, state_d;
    logic [PRBS_W-1:0] ref_q, ref_d;
    logic              have_ref_q, have_ref_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;
    logic              locked_q, locked_d;
    logic              err_word_q, err_word_d;
    logic [POP_W-1:0]  err_bits_q, err_bits_d;
    logic [CNT_W-1:0]  word_err_cnt_q, word_err_cnt_d;
    logic [CNT_W-1:0]  bit_err_cnt_q, bit_err_cnt_d;

    logic [PRBS_W-1:0] exp_word;
    logic              match;
    logic [POP_W-1:0]  diff_bits;
    logic [CNT_W-1:0]  word_base, bit_base;
    logic [CNT_W:0]    word_sum, bit_sum;

    assign exp_word = prbs_next(ref_q);
    // All-zero is the LFSR lock-up state and must never count as a match.
    assign match    = have_ref_q && (rx_bus == exp_word) && (rx_bus != '0);

    prbs_popcount u_popcount (
        .vec (rx_bus ^ exp_word),
        .cnt (diff_bits)
    );

    always_comb begin
        state_d    = state_q;
        ref_d      = ref_q;
        have_ref_d = have_ref_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        err_word_d = 1'b0;
        err_bits_d = '0;

        if (rx_valid) begin
            case (state_q)
                SEARCH: begin
                    ref_d      = rx_bus;
                    have_ref_d = 1'b1;
                    good_cnt_d = match ? good_cnt_q + GOOD_W'(1) : '0;
                    if (good_cnt_d == GOOD_W'(LOCK_THR)) begin
                        state_d   = LOCKED;
                        bad_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    ref_d = exp_word;
                    if (match) begin
                        bad_cnt_d = '0;
                    end else begin
                        err_word_d = 1'b1;
                        err_bits_d = diff_bits;
                        bad_cnt_d  = bad_cnt_q + BAD_W'(1);
                    end
                    // On loss, restart the search from the word just received.
                    if (bad_cnt_d == BAD_W'(LOSS_THR)) begin
                        state_d    = SEARCH;
                        good_cnt_d = '0;
                        ref_d      = rx_bus;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        locked_d = (state_d == LOCKED);

        // Clear takes effect first, so an error in the clear cycle is still counted.
        word_base      = err_clr ? '0 : word_err_cnt_q;
        bit_base       = err_clr ? '0 : bit_err_cnt_q;
        word_sum       = {1'b0, word_base} + (CNT_W+1)'(err_word_d);
        bit_sum        = {1'b0, bit_base} + (CNT_W+1)'(err_bits_d);
        word_err_cnt_d = word_sum[CNT_W] ? '1 : word_sum[CNT_W-1:0];
        bit_err_cnt_d  = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= SEARCH;
            ref_q          <= '0;
            have_ref_q     <= 1'b0;
            good_cnt_q     <= '0;
            bad_cnt_q      <= '0;
            locked_q       <= 1'b0;
            err_word_q     <= 1'b0;
            err_bits_q     <= '0;
            word_err_cnt_q <= '0;
            bit_err_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            ref_q          <= ref_d;
            have_ref_q     <= have_ref_d;
            good_cnt_q     <= good_cnt_d;
            bad_cnt_q      <= bad_cnt_d;
            locked_q       <= locked_d;
            err_word_q     <= err_word_d;
            err_bits_q     <= err_bits_d;
            word_err_cnt_q <= word_err_cnt_d;
            bit_err_cnt_q  <= bit_err_cnt_d;
        end
    end

    assign locked       = locked_q;
    assign err_word     = err_word_q;
    assign err_bits     = err_bits_q;
    assign word_err_cnt = word_err_cnt_q;
    assign bit_err_cnt  = bit_err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed and randomized word streams against a rule-level model,
// with a 16-bit and a 4-bit counter build driven side by side.
module tb_prbs_checker;

    localparam int LOCK_THR = 8;
    localparam int LOSS_THR = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [13:0] rx_bus = '0;
    logic        err_clr = 1'b0;

    logic        locked, err_word;
    logic [3:0]  err_bits;
    logic [15:0] word_err_cnt, bit_err_cnt;
    logic        locked4, err_word4;
    logic [3:0]  err_bits4;
    logic [3:0]  word_err_cnt4, bit_err_cnt4;

    int checks = 0;
    int errors = 0;

    // Rule-level model state
    bit          m_locked;
    bit          m_have;
    logic [13:0] m_ref;
    int          m_good, m_bad;
    bit          m_err_word;
    int          m_err_bits;
    int          m_wcnt, m_bcnt, m_wcnt4, m_bcnt4;
    logic [13:0] gen_s;

    prbs_checker #(.LOCK_THR(LOCK_THR), .LOSS_THR(LOSS_THR), .CNT_W(16)) u_dut (
        .clk (clk), .rst_n (rst_n), .rx_valid (rx_valid), .rx_bus (rx_bus),
        .err_clr (err_clr), .locked (locked), .err_word (err_word), .err_bits (err_bits),
        .word_err_cnt (word_err_cnt), .bit_err_cnt (bit_err_cnt)
    );

    prbs_checker #(.LOCK_THR(LOCK_THR), .LOSS_THR(LOSS_THR), .CNT_W(4)) u_dut4 (
        .clk (clk), .rst_n (rst_n), .rx_valid (rx_valid), .rx_bus (rx_bus),
        .err_clr (err_clr), .locked (locked4), .err_word (err_word4), .err_bits (err_bits4),
        .word_err_cnt (word_err_cnt4), .bit_err_cnt (bit_err_cnt4)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] ref_nxt(input logic [13:0] s);
        return {s[13] ^ s[4] ^ s[2] ^ s[0], s[13:1]};
    endfunction

    function automatic int sat_add(input int base, input int inc, input int max);
        return (base + inc > max) ? max : base + inc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_have = 0; m_ref = '0; m_good = 0; m_bad = 0;
        m_err_word = 0; m_err_bits = 0;
        m_wcnt = 0; m_bcnt = 0; m_wcnt4 = 0; m_bcnt4 = 0;
    endtask

    task automatic model_step(input bit v, input logic [13:0] bus, input bit clr);
        logic [13:0] e;
        bit          ok;
        m_err_word = 0;
        m_err_bits = 0;
        if (v) begin
            e  = ref_nxt(m_ref);
            ok = m_have && (bus == e) && (bus != 14'h0);
            if (!m_locked) begin
                m_ref  = bus;
                m_have = 1;
                m_good = ok ? m_good + 1 : 0;
                if (m_good == LOCK_THR) begin
                    m_locked = 1;
                    m_bad    = 0;
                end
            end else begin
                m_ref = e;
                if (ok) m_bad = 0;
                else begin
                    m_err_word = 1;
                    m_err_bits = $countones(bus ^ e);
                    m_bad++;
                end
                if (m_bad == LOSS_THR) begin
                    m_locked = 0;
                    m_good   = 0;
                    m_ref    = bus;
                end
            end
        end
        if (clr) begin
            m_wcnt = 0; m_bcnt = 0; m_wcnt4 = 0; m_bcnt4 = 0;
        end
        m_wcnt  = sat_add(m_wcnt,  int'(m_err_word), 16'hFFFF);
        m_bcnt  = sat_add(m_bcnt,  m_err_bits,       16'hFFFF);
        m_wcnt4 = sat_add(m_wcnt4, int'(m_err_word), 15);
        m_bcnt4 = sat_add(m_bcnt4, m_err_bits,       15);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".locked"},   32'(locked),        32'(m_locked));
        chk({tag, ".err_word"}, 32'(err_word),      32'(m_err_word));
        chk({tag, ".err_bits"}, 32'(err_bits),      32'(m_err_bits));
        chk({tag, ".wcnt"},     32'(word_err_cnt),  32'(m_wcnt));
        chk({tag, ".bcnt"},     32'(bit_err_cnt),   32'(m_bcnt));
        chk({tag, ".locked4"},  32'(locked4),       32'(m_locked));
        chk({tag, ".wcnt4"},    32'(word_err_cnt4), 32'(m_wcnt4));
        chk({tag, ".bcnt4"},    32'(bit_err_cnt4),  32'(m_bcnt4));
    endtask

    task automatic step(input string tag, input bit v, input logic [13:0] bus, input bit clr);
        rx_valid = v;
        rx_bus   = bus;
        err_clr  = clr;
        model_step(v, bus, clr);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic send_good(input string tag);
        step(tag, 1'b1, gen_s, 1'b0);
        gen_s = ref_nxt(gen_s);
    endtask

    task automatic send_err(input string tag, input logic [13:0] mask, input bit clr);
        step(tag, 1'b1, gen_s ^ mask, clr);
        gen_s = ref_nxt(gen_s);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_valid = 1'b0; rx_bus = '0; err_clr = 1'b0;
        model_reset();
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        gen_s = 14'h0001;
    endtask

    initial begin
        bit          v;
        int          r;
        int          nvalid;
        logic [13:0] bus;

        model_reset();
        do_reset();

        // Lock from seed 0x0001: locked rises on the 9th valid word.
        for (int i = 0; i < 9; i++) begin
            send_good("lock");
            if (i == 7) chk("lock.not_yet", 32'(locked), 32'd0);
        end
        chk("lock.ninth", 32'(locked), 32'd1);

        // Single-bit hit, then flywheel recovers on the next correct word.
        send_err("hit1", 14'h0004, 1'b0);
        chk("hit1.bits", 32'(err_bits), 32'd1);
        chk("hit1.wcnt", 32'(word_err_cnt), 32'd1);
        send_good("hit1.after");
        chk("hit1.after.err", 32'(err_word), 32'd0);

        // Multi-bit hit.
        send_err("hit4", 14'h3003, 1'b0);
        chk("hit4.bits", 32'(err_bits), 32'd4);
        chk("hit4.bcnt", 32'(bit_err_cnt), 32'd5);

        // Loss of lock on a constant word, then re-lock from the live sequence.
        for (int i = 0; i < 4; i++) step("loss", 1'b1, 14'h1234, 1'b0);
        chk("loss.locked", 32'(locked), 32'd0);
        for (int i = 0; i < 9; i++) send_good("relock");
        chk("relock.locked", 32'(locked), 32'd1);

        // Clear alone, then clear with an error in the same cycle.
        step("clr", 1'b0, 14'h0, 1'b1);
        chk("clr.wcnt", 32'(word_err_cnt), 32'd0);
        send_err("clr_err", 14'h0004, 1'b1);
        chk("clr_err.wcnt", 32'(word_err_cnt), 32'd1);
        send_good("clr_err.after");

        // Saturation: the 4-bit build pins at 0xF, lock is held by interleaved good words.
        for (int i = 0; i < 20; i++) begin
            send_err("sat", 14'h3003, 1'b0);
            send_good("sat.good");
        end
        chk("sat.wcnt4", 32'(word_err_cnt4), 32'hF);
        chk("sat.bcnt4", 32'(bit_err_cnt4), 32'hF);
        chk("sat.wcnt16", 32'(word_err_cnt), 32'd21);

        // Async reset while locked: outputs drop before any clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.locked", 32'(locked), 32'd0);
        chk("arst.wcnt", 32'(word_err_cnt), 32'd0);
        chk("arst.bcnt", 32'(bit_err_cnt), 32'd0);
        chk("arst.err_word", 32'(err_word), 32'd0);
        do_reset();

        // All-zero input never locks.
        for (int i = 0; i < 20; i++) step("zero", 1'b1, 14'h0, 1'b0);
        chk("zero.locked", 32'(locked), 32'd0);

        // Gapped stream locks on the same 9th valid word.
        do_reset();
        nvalid = 0;
        while (nvalid < 9) begin
            v = ($urandom_range(0, 1) == 1);
            if (v) begin
                send_good("gap");
                nvalid++;
            end else step("gap.idle", 1'b0, 14'($urandom), 1'b0);
            if (nvalid == 8) chk("gap.not_yet", 32'(locked), 32'd0);
        end
        chk("gap.locked", 32'(locked), 32'd1);

        // Randomized traffic: gaps, bit errors, junk words and occasional clears.
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 19);
            if (!v) begin
                step("rnd.idle", 1'b0, 14'($urandom), $urandom_range(0, 31) == 0);
            end else begin
                if (r == 0) bus = gen_s ^ 14'($urandom_range(1, 16383));
                else if (r == 1) bus = 14'($urandom);
                else bus = gen_s;
                step("rnd", 1'b1, bus, $urandom_range(0, 31) == 0);
                gen_s = ref_nxt(gen_s);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
